// File: rtl/pipelined_segmented_adder.sv
// pipelined_segmented_adder: WIDTH-bit adder cut into SEG-bit ripple segments, one registered carry per stage.
// Define APPROX_ADDER_EN to honour the per-beat approx input, which cuts every inter-segment carry.
module pipelined_segmented_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout
);
    localparam int NSEG = WIDTH / SEG;
    logic adv;
    logic [NSEG-1:0] v, c, co;
    logic [SEG-1:0] ps [NSEG];
    logic [WIDTH-1:0] a [NSEG], b [NSEG], s [NSEG];
    logic unused_ok;
`ifdef APPROX_ADDER_EN
    logic [NSEG-1:0] ap;
    assign unused_ok = ^{a[NSEG-1], b[NSEG-1], ap[NSEG-1]};
`else
    assign unused_ok = ^{a[NSEG-1], b[NSEG-1], approx};
`endif
    assign out_valid = v[NSEG-1];
    assign out = s[NSEG-1];
    assign cout = c[NSEG-1];
    assign adv = !out_valid | out_ready;
    assign in_ready = adv;
    genvar k;
    for (k = 0; k < NSEG; k++) begin : g_seg
        logic ci;
        logic [SEG-1:0] x, y;
        if (k == 0) begin : g_lo
            assign x = in1[SEG-1:0];
            assign y = in2[SEG-1:0];
            assign ci = cin;
        end else begin : g_hi
            assign x = a[k-1][k*SEG +: SEG];
            assign y = b[k-1][k*SEG +: SEG];
`ifdef APPROX_ADDER_EN
            assign ci = c[k-1] & !ap[k-1];
`else
            assign ci = c[k-1];
`endif
        end
        assign {co[k], ps[k]} = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
    end
    // s[i] carries the finished low segments forward so the whole sum lands aligned in the last stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            c <= '0;
`ifdef APPROX_ADDER_EN
            ap <= '0;
`endif
            for (int i = 0; i < NSEG; i++) begin
                a[i] <= '0;
                b[i] <= '0;
                s[i] <= '0;
            end
        end else if (adv) begin
            c <= co;
            v[0] <= in_valid;
            a[0] <= in1;
            b[0] <= in2;
            s[0] <= '0;
            s[0][SEG-1:0] <= ps[0];
`ifdef APPROX_ADDER_EN
            ap[0] <= approx;
`endif
            for (int i = 1; i < NSEG; i++) begin
                v[i] <= v[i-1];
                a[i] <= a[i-1];
                b[i] <= b[i-1];
                s[i] <= s[i-1];
                s[i][i*SEG +: SEG] <= ps[i];
`ifdef APPROX_ADDER_EN
                ap[i] <= ap[i-1];
`endif
            end
        end
    end
endmodule
